ssd_capture: RTL and testbench
==============================

# ssd_capture

Receive-side monitor for the multiplexed four-digit seven-segment display bus driven by the stopwatch display path. Samples the active-low digit-select (anode) ring and the active-low segment bus, waits for each strobe to settle, decodes each digit's segment pattern back to a BCD value, and publishes complete four-digit frames with error flags. Used in the bench and on-board to self-check what the display driver actually emits.

## Interface
- `SETTLE`, 4: consecutive identical samples of (anode, seg) required before a digit is captured; legal range 1–255.
- `TIMEOUT`, 1024: cycles without a capture before `stall` sets; legal range 2–65535.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `anode`  in  4  digit select, active-low one-hot: 1110 = digit0 (ones), 1101 = digit1 (tens), 1011 = digit2, 0111 = digit3; 1111 = blanking gap.
- `seg`  in  7  segments a..g on bits 6..0, active-low.
- `digits`  out  16  captured frame, digit0 in [3:0] … digit3 in [15:12].
- `blank`  out  4  per digit: pattern was 1111111.
- `code_err`  out  4  per digit: pattern was neither a numeral nor blank.
- `frame_valid`  out  1  one-cycle pulse when `digits`/`blank`/`code_err` update.
- `seq_err`  out  1  one-cycle pulse on out-of-order strobe.
- `stall`  out  1  level; scan has stopped.

## Operation
- Decode (bits 6..0): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9; 1111111→value F, blank=1; anything else→value E, code_err=1.
- FSM states HUNT, SETTLE, HOLD. `idx` (2 bits) = expected digit.
- HUNT: wait for anode==1110; then `idx`=0, clear settle counter, go SETTLE. Other anode values ignored.
- SETTLE: counter increments while sampled (anode, seg) equal previous sample; seg change restarts counter at 1. On reaching `SETTLE`: decode `seg` into shadow slot `idx`, go HOLD. Anode change before capture: `seq_err` pulse, go HUNT.
- HOLD: anode unchanged or 1111 → stay. Anode one-hot-low with index idx+1 (mod 4) → `idx` advances, go SETTLE. Any other value → `seq_err` pulse; if new anode is 1110 go SETTLE with `idx`=0, else HUNT.
- Frame completion: capture of digit3 copies shadow (including that digit) to `digits`/`blank`/`code_err` and pulses `frame_valid`. Partial frames never reach outputs; shadow discarded on `seq_err`.
- Watchdog: counter clears on every capture, saturates at `TIMEOUT`; reaching it sets `stall`, forces HUNT. `stall` clears on next capture.
- Reset (reset==0 at edge): HUNT, `digits`=16'hFFFF, `blank`=4'b1111, `code_err`=0, `frame_valid`=0, `seq_err`=0, `stall`=0, all counters 0. Reset mid-frame discards shadow.

## Timing
- All outputs registered. `frame_valid` and new `digits` appear together the cycle after the digit3 capture edge.
- Sync path off: digit captured on the `SETTLE`-th consecutive rising edge that samples the stable pair. Sync on: +2 cycles for all inputs.
- `seq_err` and `frame_valid` never assert in the same cycle; if digit3 capture and an error coincide (impossible by FSM) error takes precedence.
- Watchdog and frame completion in same cycle: capture wins, `stall` stays 0.

## Configuration
- `SSD_CAPTURE_SYNC_EN` defined: `anode` and `seg` pass through a two-flop synchronizer (reset to 1111/1111111) before the FSM; required for asynchronous or off-board sources.
- Undefined: inputs sampled directly; zero added latency.

## Structure
- Package `ssd_pkg`: segment constants SEG_0…SEG_9, SEG_BLANK; anode constants AN_D0…AN_D3, AN_OFF; FSM state enum.
- Sub-module `ssd_seg_decode`: combinational 7-bit pattern → {value[3:0], blank, code_err}.

## Test plan
- Reset then scan 1110/0000001, 1101/1001111, 1011/1111111, 0111/1111111, each held 6 cycles, SETTLE=4 → one `frame_valid`, `digits`=16'hFF10, `blank`=4'b1100, `code_err`=0.
- Same scan with digit1 seg=1111110 → `digits`[7:4]=E, `code_err`=4'b0010.
- Strobe order 1110 then 1011 → `seq_err` pulse, no `frame_valid`, `digits` unchanged.
- Hold anode=1101 constant for 1100 cycles, TIMEOUT=1024 → `stall`=1 at cycle 1024 after last capture; resume valid scan → `stall` clears at first capture, frame after full scan.
- Digit held only 3 cycles with SETTLE=4 → no capture, `seq_err` on next strobe.
- Assert reset after digit2 captured → outputs return to reset values, next full scan yields exactly one frame.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants, state type and anode helper for the seven-segment capture block
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Active-low one-hot strobe for a digit index.
  function automatic logic [3:0] an_for(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// rtl/ssd_seg_decode.sv - active-low segment pattern back to BCD with blank/error flags
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       code_err
);

  always_comb begin
    value    = 4'hE;
    blank    = 1'b0;
    code_err = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        value = 4'hF;
        blank = 1'b1;
      end
      default:   code_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// rtl/ssd_capture.sv - multiplexed seven-segment bus monitor publishing decoded four-digit frames
// SSD_CAPTURE_SYNC_EN: when defined, anode/seg pass through a two-flop synchronizer first.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  code_err,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        stall
);

  localparam logic [8:0]  SETTLE_V  = 9'(SETTLE);
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  logic [3:0] an_s;
  logic [6:0] seg_s;

`ifdef SSD_CAPTURE_SYNC_EN
  logic [3:0] an_m;
  logic [6:0] seg_m;

  always_ff @(posedge clock) begin
    if (!reset) begin
      an_m  <= AN_OFF;
      an_s  <= AN_OFF;
      seg_m <= SEG_BLANK;
      seg_s <= SEG_BLANK;
    end else begin
      an_m  <= anode;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;
    end
  end
`else
  assign an_s  = anode;
  assign seg_s = seg;
`endif

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] wd;
  logic [3:0]  prev_an;
  logic [6:0]  prev_seg;

  // Slots 0..2 only; digit3 goes straight from the decoder to the outputs.
  logic [11:0] sh_dig;
  logic [2:0]  sh_blank;
  logic [2:0]  sh_err;

  logic [3:0]  dec_val;
  logic        dec_blank;
  logic        dec_err;

  logic        cap;
  logic        err;
  logic        enter;
  logic [1:0]  enter_idx;
  logic [1:0]  cap_idx;
  logic        wd_reach;
  logic        frame_done;

  ssd_seg_decode u_dec (
    .seg      (seg_s),
    .value    (dec_val),
    .blank    (dec_blank),
    .code_err (dec_err)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    cap       = 1'b0;
    err       = 1'b0;
    enter     = 1'b0;
    enter_idx = 2'd0;
    case (state)
      ST_HUNT: begin
        if (an_s == AN_D0) begin
          enter     = 1'b1;
          enter_idx = 2'd0;
        end
      end
      ST_SETTLE: begin
        if (an_s != prev_an) begin
          err     = 1'b1;
          state_n = ST_HUNT;
        end else if (seg_s != prev_seg) begin
          cnt_n = 8'd1;
          cap   = (SETTLE_V == 9'd1);
        end else begin
          cnt_n = cnt + 8'd1;
          cap   = (({1'b0, cnt} + 9'd1) == SETTLE_V);
        end
      end
      ST_HOLD: begin
        if (an_s != an_for(idx) && an_s != AN_OFF) begin
          if (an_s == an_for(idx + 2'd1)) begin
            enter     = 1'b1;
            enter_idx = idx + 2'd1;
          end else begin
            err = 1'b1;
            if (an_s == AN_D0) begin
              enter     = 1'b1;
              enter_idx = 2'd0;
            end else begin
              state_n = ST_HUNT;
            end
          end
        end
      end
      default: state_n = ST_HUNT;
    endcase

    // The edge that first sees a new strobe already counts as one stable sample.
    if (enter) begin
      idx_n   = enter_idx;
      cnt_n   = 8'd1;
      state_n = ST_SETTLE;
      cap     = (SETTLE_V == 9'd1);
    end
    if (cap) state_n = ST_HOLD;

    cap_idx    = idx_n;
    frame_done = cap && (cap_idx == 2'd3) && !err;
    wd_reach   = !cap && (wd != TIMEOUT_V) && (({1'b0, wd} + 17'd1) == {1'b0, TIMEOUT_V});
    if (wd_reach) state_n = ST_HUNT;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_HUNT;
      idx         <= 2'd0;
      cnt         <= 8'd0;
      wd          <= 16'd0;
      prev_an     <= AN_OFF;
      prev_seg    <= SEG_BLANK;
      sh_dig      <= 12'hFFF;
      sh_blank    <= 3'b111;
      sh_err      <= 3'b000;
      digits      <= 16'hFFFF;
      blank       <= 4'b1111;
      code_err    <= 4'b0000;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      stall       <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      prev_an     <= an_s;
      prev_seg    <= seg_s;
      frame_valid <= frame_done;
      seq_err     <= err;

      if (cap) begin
        wd    <= 16'd0;
        stall <= 1'b0;
      end else if (wd_reach) begin
        wd    <= TIMEOUT_V;
        stall <= 1'b1;
      end else if (wd != TIMEOUT_V) begin
        wd <= wd + 16'd1;
      end

      if (err || wd_reach) begin
        sh_dig   <= 12'hFFF;
        sh_blank <= 3'b111;
        sh_err   <= 3'b000;
      end

      if (cap) begin
        case (cap_idx)
          2'd0: begin
            sh_dig[3:0] <= dec_val;
            sh_blank[0] <= dec_blank;
            sh_err[0]   <= dec_err;
          end
          2'd1: begin
            sh_dig[7:4] <= dec_val;
            sh_blank[1] <= dec_blank;
            sh_err[1]   <= dec_err;
          end
          2'd2: begin
            sh_dig[11:8] <= dec_val;
            sh_blank[2]  <= dec_blank;
            sh_err[2]    <= dec_err;
          end
          default: begin
            if (frame_done) begin
              digits   <= {dec_val, sh_dig};
              blank    <= {dec_blank, sh_blank};
              code_err <= {dec_err, sh_err};
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd_capture.sv
// tb/tb_ssd_capture.sv - directed vector bench for ssd_capture (SETTLE=4, TIMEOUT=1024)
module tb_ssd_capture;

  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AX = 4'b1111;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [0:7][3:0] H6 = {8{4'd6}};
  localparam logic [0:7][3:0] SCAN = {A0, A1, A2, A3, AX, AX, AX, AX};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  anode = 4'b1111;
  logic [6:0]  seg   = 7'b1111111;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  code_err;
  logic        frame_valid;
  logic        seq_err;
  logic        stall;

  ssd_capture #(.SETTLE(4), .TIMEOUT(1024)) dut (
    .clock       (clock),
    .reset       (reset),
    .anode       (anode),
    .seg         (seg),
    .digits      (digits),
    .blank       (blank),
    .code_err    (code_err),
    .frame_valid (frame_valid),
    .seq_err     (seq_err),
    .stall       (stall)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int both_cnt = 0;

  always @(posedge clock) begin
    #1;
    if (frame_valid) fv_cnt++;
    if (seq_err) se_cnt++;
    if (frame_valid && seq_err) both_cnt++;
  end

  typedef struct {
    string            name;
    bit               do_reset;
    int               n;
    logic [0:7][3:0]  an;
    logic [0:7][6:0]  sg;
    logic [0:7][3:0]  hold;
    int               gap;
    int               exp_fv;
    int               exp_se;
    logic [15:0]      exp_dig;
    logic [3:0]       exp_blank;
    logic [3:0]       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clock);
      anode = a;
      seg   = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    anode = AX;
    seg   = SB;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic add(input string nm, input bit rst, input int n, input logic [0:7][3:0] an,
                     input logic [0:7][6:0] sg, input logic [0:7][3:0] hold, input int gap,
                     input int efv, input int ese, input logic [15:0] ed,
                     input logic [3:0] eb, input logic [3:0] ee);
    vec_t v;
    v.name = nm; v.do_reset = rst; v.n = n; v.an = an; v.sg = sg; v.hold = hold; v.gap = gap;
    v.exp_fv = efv; v.exp_se = ese; v.exp_dig = ed; v.exp_blank = eb; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int fv0, se0;
    if (v.do_reset) do_reset();
    fv0 = fv_cnt;
    se0 = se_cnt;
    for (int i = 0; i < v.n; i++) begin
      drive(v.an[i], v.sg[i], int'(v.hold[i]));
      if (v.gap > 0) drive(AX, SB, v.gap);
    end
    drive(AX, SB, 3);
    @(negedge clock);
    check($sformatf("%s.frames", v.name), fv_cnt - fv0, v.exp_fv);
    check($sformatf("%s.seq_err", v.name), se_cnt - se0, v.exp_se);
    check($sformatf("%s.digits", v.name), digits, v.exp_dig);
    check($sformatf("%s.blank", v.name), blank, v.exp_blank);
    check($sformatf("%s.code_err", v.name), code_err, v.exp_err);
  endtask

  initial begin
    int fv0;

    add("basic", 1, 4, SCAN, {S0, S1, SB, SB, SB, SB, SB, SB}, H6, 0, 1, 0, 16'hFF10, 4'b1100, 4'b0000);
    add("code_err", 1, 4, SCAN, {S0, 7'b1111110, SB, SB, SB, SB, SB, SB}, H6, 0, 1, 0, 16'hFFE0, 4'b1100, 4'b0010);
    add("d3579", 1, 4, SCAN, {S3, S5, S7, S9, SB, SB, SB, SB}, H6, 0, 1, 0, 16'h9753, 4'b0000, 4'b0000);
    add("d2468_wrap", 0, 4, SCAN, {S2, S4, S6, S8, SB, SB, SB, SB}, H6, 0, 1, 0, 16'h8642, 4'b0000, 4'b0000);
    add("bad_order", 0, 2, {A0, A2, AX, AX, AX, AX, AX, AX}, {S1, S2, SB, SB, SB, SB, SB, SB}, H6, 0, 0, 1, 16'h8642, 4'b0000, 4'b0000);
    add("short_hold", 0, 2, {A0, A1, AX, AX, AX, AX, AX, AX}, {S0, S1, SB, SB, SB, SB, SB, SB},
        {4'd3, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6}, 0, 0, 1, 16'h8642, 4'b0000, 4'b0000);
    add("gaps", 0, 4, SCAN, {S1, S2, S3, S4, SB, SB, SB, SB}, H6, 2, 1, 0, 16'h4321, 4'b0000, 4'b0000);
    add("two_frames", 0, 8, {A0, A1, A2, A3, A0, A1, A2, A3}, {S0, S1, S2, S3, S5, S6, S7, S8}, H6, 0, 2, 0, 16'h8765, 4'b0000, 4'b0000);
    add("seg_restart", 0, 3, {A0, A0, A1, AX, AX, AX, AX, AX}, {S8, S9, S1, SB, SB, SB, SB, SB},
        {4'd3, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6}, 0, 0, 1, 16'h8765, 4'b0000, 4'b0000);
    add("mixed", 0, 4, SCAN, {SB, S0, S7, 7'b0110000, SB, SB, SB, SB}, H6, 0, 1, 0, 16'hE70F, 4'b0001, 4'b1000);

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst.digits", digits, 16'hFFFF);
    check("rst.blank", blank, 4'b1111);
    check("rst.code_err", code_err, 4'b0000);
    check("rst.frame_valid", frame_valid, 1'b0);
    check("rst.seq_err", seq_err, 1'b0);
    check("rst.stall", stall, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Capture latency: digit3 captured on its 4th sampled edge, frame_valid for one cycle.
    do_reset();
    drive(A0, S4, 6);
    drive(A1, S3, 6);
    drive(A2, S2, 6);
    drive(A3, S1, 3);
    @(negedge clock);
    check("lat.fv_before", frame_valid, 1'b0);
    @(negedge clock);
    check("lat.fv_at", frame_valid, 1'b1);
    check("lat.digits", digits, 16'h1234);
    @(negedge clock);
    check("lat.fv_after", frame_valid, 1'b0);

    // Watchdog: a stuck strobe never captures.
    do_reset();
    drive(A1, S1, 1000);
    check("wd.stall_early", stall, 1'b0);
    drive(A1, S1, 30);
    check("wd.stall_set", stall, 1'b1);
    drive(A0, S5, 3);
    check("wd.stall_hold", stall, 1'b1);
    fv0 = fv_cnt;
    drive(A0, S5, 3);
    check("wd.stall_clear", stall, 1'b0);
    drive(A1, S6, 6);
    drive(A2, S7, 6);
    drive(A3, S8, 6);
    drive(AX, SB, 3);
    check("wd.frames", fv_cnt - fv0, 1);
    check("wd.digits", digits, 16'h8765);

    // Reset after digit2 captured discards the partial frame.
    drive(A0, S9, 6);
    drive(A1, S9, 6);
    drive(A2, S9, 6);
    do_reset();
    @(negedge clock);
    check("mid.digits", digits, 16'hFFFF);
    check("mid.blank", blank, 4'b1111);
    check("mid.code_err", code_err, 4'b0000);
    check("mid.stall", stall, 1'b0);
    fv0 = fv_cnt;
    drive(A3, S1, 6);
    drive(A0, S0, 6);
    drive(A1, S1, 6);
    drive(A2, S2, 6);
    drive(A3, S3, 6);
    drive(AX, SB, 3);
    check("mid.frames", fv_cnt - fv0, 1);
    check("mid.digits_after", digits, 16'h3210);

    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
